// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enigma_pkg
// Description : Shared Enigma datapath types, rotor wiring tables (wheels
//               I..III, forward and inverse) and the mod-26 add/sub helper
//               used by both the forward and return rotor paths.
// Contents    : letter_t, N_LETTERS, FWD_*/INV_* tables, mod26_add_sub(),
//               inv_wiring()
// Revision    : 1.0 - initial release
// ============================================================================
package enigma_pkg;

    typedef logic [4:0] letter_t;

    localparam int N_LETTERS = 26;

    // Forward wirings (entry contact -> exit contact), A = 0
    localparam letter_t FWD_I [N_LETTERS] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25,
        5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15,
        5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9
    };
    localparam letter_t FWD_II [N_LETTERS] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,
        5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13,
        5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4
    };
    localparam letter_t FWD_III [N_LETTERS] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19,
        5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,
        5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14
    };

    // Inverse wirings (exit contact -> entry contact)
    // I   = UWYGADFPVZBECKMTHXSLRINQOJ
    localparam letter_t INV_I [N_LETTERS] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25,
        5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11,
        5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9
    };
    // II  = AJPCZWRLFBDKOTYUQGENHXMIVS
    localparam letter_t INV_II [N_LETTERS] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,
        5'd3,  5'd10, 5'd14, 5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13,
        5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18
    };
    // III = TAGBPCSDQEUFVNZHYIXJWLRKOM
    localparam letter_t INV_III [N_LETTERS] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,
        5'd20, 5'd5,  5'd21, 5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,
        5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12
    };

    // (a + b + 26 - c) mod 26 for in-range operands. The 7-bit sum spans
    // 1..76, so at most one of the two conditional subtractions applies.
    function automatic letter_t mod26_add_sub(letter_t a, letter_t b, letter_t c);
        logic [6:0] w_sum;
        w_sum = {2'b00, a} + {2'b00, b} + 7'd26 - {2'b00, c};
        if (w_sum >= 7'd52) begin
            w_sum = w_sum - 7'd52;
        end else if (w_sum >= 7'd26) begin
            w_sum = w_sum - 7'd26;
        end
        return w_sum[4:0];
    endfunction

    // Inverse wiring lookup; an out-of-table index (only possible for a
    // letter already flagged as erroneous) returns 0 rather than indexing
    // past the table.
    function automatic letter_t inv_wiring(int wheel, letter_t idx);
        letter_t w_res;
        w_res = '0;
        if (idx < 5'(N_LETTERS)) begin
            case (wheel)
                1:       w_res = INV_I[idx];
                2:       w_res = INV_II[idx];
                default: w_res = INV_III[idx];
            endcase
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enigma_return_path_if.sv
`default_nettype none
// ============================================================================
// Module      : enigma_return_path_if
// Description : Input and output valid/ready channels of the return-path
//               rotor pipeline.
// Ports       : in_valid/in_ready/char_in/pos_*/ring_*  (letter in)
//               out_valid/out_ready/char_out/out_err     (letter out)
//               master = letter source / sink, slave = pipeline
// Revision    : 1.0 - initial release
// ============================================================================
interface enigma_return_path_if;
    import enigma_pkg::*;

    logic    in_valid;
    logic    in_ready;
    letter_t char_in;
    letter_t pos_l;
    letter_t pos_m;
    letter_t pos_r;
    letter_t ring_l;
    letter_t ring_m;
    letter_t ring_r;
    logic    out_valid;
    logic    out_ready;
    letter_t char_out;
    logic    out_err;

    modport master (
        output in_valid, char_in, pos_l, pos_m, pos_r, ring_l, ring_m, ring_r,
        output out_ready,
        input  in_ready, out_valid, char_out, out_err
    );

    modport slave (
        input  in_valid, char_in, pos_l, pos_m, pos_r, ring_l, ring_m, ring_r,
        input  out_ready,
        output in_ready, out_valid, char_out, out_err
    );

endinterface
`default_nettype wire

// File: rtl/enigma_inv_rotor_stage.sv
`default_nettype none
// ============================================================================
// Module      : enigma_inv_rotor_stage
// Description : One return-path rotor: inverse wiring with position/ring
//               offset, followed by its pipeline register slice.
// Ports       : clk, rst_n          clock, async active-low reset
//               i_advance           slice may load this cycle
//               i_valid/i_char/i_err  incoming letter
//               i_pos/i_ring        rotor position and ring setting
//               o_valid/o_char/o_err  registered letter
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_inv_rotor_stage
    import enigma_pkg::*;
#(
    parameter int WHEEL = 1
) (
    input  wire     clk,
    input  wire     rst_n,
    input  wire     i_advance,
    input  wire     i_valid,
    input  letter_t i_char,
    input  wire     i_err,
    input  letter_t i_pos,
    input  letter_t i_ring,
    output logic    o_valid,
    output letter_t o_char,
    output logic    o_err
);

    letter_t w_contact;
    letter_t w_wired;
    letter_t w_result;

    logic    r_valid;
    letter_t r_char;
    logic    r_err;

    always_comb begin
        // Shift into the rotor frame, pass through the wiring, shift back.
        w_contact = mod26_add_sub(i_char, i_pos, i_ring);
        w_wired   = inv_wiring(WHEEL, w_contact);
        w_result  = i_err ? '0 : mod26_add_sub(w_wired, i_ring, i_pos);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_char  <= '0;
            r_err   <= 1'b0;
        end else if (i_advance) begin
            r_valid <= i_valid;
            // Data only moves with a real letter, so a bubble never
            // disturbs the last value presented downstream.
            if (i_valid) begin
                r_char <= w_result;
                r_err  <= i_err;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_char  = r_char;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/enigma_return_path.sv
`default_nettype none
// ============================================================================
// Module      : enigma_return_path
// Description : Return-path rotor pipeline. The reflected letter passes
//               back through the left, middle and right rotors (inverse
//               wirings) in three valid/ready stages, one letter per cycle.
//               Rotor positions/rings travel with each letter.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    enigma_return_path_if.slave (letter in / letter out)
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_return_path
    import enigma_pkg::*;
#(
    parameter int WHEEL_L = 1,
    parameter int WHEEL_M = 2,
    parameter int WHEEL_R = 3
) (
    input  wire                  clk,
    input  wire                  rst_n,
    enigma_return_path_if.slave  bus
);

    logic    w_in_err;
    logic    w_s1_adv;
    logic    w_s2_adv;
    logic    w_s3_adv;

    logic    w_s1_valid;
    letter_t w_s1_char;
    logic    w_s1_err;
    logic    w_s2_valid;
    letter_t w_s2_char;
    logic    w_s2_err;
    logic    w_s3_valid;
    letter_t w_s3_char;
    logic    w_s3_err;

    // Settings still needed by later stages: {pos_m, ring_m, pos_r, ring_r}
    logic [19:0] r_s1_carry;
    // {pos_r, ring_r}
    logic [9:0]  r_s2_carry;

    always_comb begin
        w_in_err = (bus.char_in >= 5'(N_LETTERS)) |
                   (bus.pos_l   >= 5'(N_LETTERS)) |
                   (bus.pos_m   >= 5'(N_LETTERS)) |
                   (bus.pos_r   >= 5'(N_LETTERS)) |
                   (bus.ring_l  >= 5'(N_LETTERS)) |
                   (bus.ring_m  >= 5'(N_LETTERS)) |
                   (bus.ring_r  >= 5'(N_LETTERS));

        // Back-pressure ripples combinationally from out_ready to in_ready;
        // an empty stage always advances, so bubbles collapse.
        w_s3_adv = !w_s3_valid || bus.out_ready;
        w_s2_adv = !w_s2_valid || w_s3_adv;
        w_s1_adv = !w_s1_valid || w_s2_adv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_carry <= '0;
            r_s2_carry <= '0;
        end else begin
            if (w_s1_adv && bus.in_valid) begin
                r_s1_carry <= {bus.pos_m, bus.ring_m, bus.pos_r, bus.ring_r};
            end
            if (w_s2_adv && w_s1_valid) begin
                r_s2_carry <= r_s1_carry[9:0];
            end
        end
    end

    enigma_inv_rotor_stage #(.WHEEL(WHEEL_L)) u_stage_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (w_s1_adv),
        .i_valid   (bus.in_valid),
        .i_char    (bus.char_in),
        .i_err     (w_in_err),
        .i_pos     (bus.pos_l),
        .i_ring    (bus.ring_l),
        .o_valid   (w_s1_valid),
        .o_char    (w_s1_char),
        .o_err     (w_s1_err)
    );

    enigma_inv_rotor_stage #(.WHEEL(WHEEL_M)) u_stage_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (w_s2_adv),
        .i_valid   (w_s1_valid),
        .i_char    (w_s1_char),
        .i_err     (w_s1_err),
        .i_pos     (r_s1_carry[19:15]),
        .i_ring    (r_s1_carry[14:10]),
        .o_valid   (w_s2_valid),
        .o_char    (w_s2_char),
        .o_err     (w_s2_err)
    );

    enigma_inv_rotor_stage #(.WHEEL(WHEEL_R)) u_stage_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (w_s3_adv),
        .i_valid   (w_s2_valid),
        .i_char    (w_s2_char),
        .i_err     (w_s2_err),
        .i_pos     (r_s2_carry[9:5]),
        .i_ring    (r_s2_carry[4:0]),
        .o_valid   (w_s3_valid),
        .o_char    (w_s3_char),
        .o_err     (w_s3_err)
    );

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = w_s3_valid;
    assign bus.char_out  = w_s3_char;
    assign bus.out_err   = w_s3_err;

endmodule
`default_nettype wire

// File: tb/tb_enigma_return_path.sv
`default_nettype none
// ============================================================================
// Module      : tb_enigma_return_path
// Description : Self-checking bench for enigma_return_path. A letter-level
//               model (string wiring tables, integer mod-26 arithmetic)
//               predicts each accepted letter; a queue tracks letters in
//               flight and one compare process checks the outputs on every
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_enigma_return_path;
    import enigma_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enigma_return_path_if bus();

    enigma_return_path #(.WHEEL_L(1), .WHEEL_M(2), .WHEEL_R(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int ch;
        int err;
        int acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int inv_tab(input int wheel, input int idx);
        string s;
        case (wheel)
            1:       s = "UWYGADFPVZBECKMTHXSLRINQOJ";
            2:       s = "AJPCZWRLFBDKOTYUQGENHXMIVS";
            default: s = "TAGBPCSDQEUFVNZHYIXJWLRKOM";
        endcase
        return int'(s.getc(idx)) - 65;
    endfunction

    // Letter-level return path: left, middle, right rotor inverses.
    task automatic model(input int c, input int pl, input int pm, input int pr,
                         input int rl, input int rm, input int rr,
                         output int oc, output int oe);
        int p[3];
        int r[3];
        int x;
        int t;
        p[0] = pl; p[1] = pm; p[2] = pr;
        r[0] = rl; r[1] = rm; r[2] = rr;
        if (c > 25 || pl > 25 || pm > 25 || pr > 25 || rl > 25 || rm > 25 || rr > 25) begin
            oc = 0;
            oe = 1;
        end else begin
            x = c;
            for (int k = 0; k < 3; k++) begin
                t = (x + p[k] - r[k] + 26) % 26;
                x = (inv_tab(k + 1, t) - p[k] + r[k] + 26) % 26;
            end
            oc = x;
            oe = 0;
        end
    endtask

    // Compare process: runs every falling edge.
    initial begin
        bit   exp_valid;
        exp_t e;
        int   oc;
        int   oe;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q.delete();
                check("rst_out_valid", int'(bus.out_valid), 0);
                check("rst_in_ready", int'(bus.in_ready), 1);
                check("rst_char_out", int'(bus.char_out), 0);
                check("rst_out_err", int'(bus.out_err), 0);
            end else begin
                exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 3);
                check("out_valid", int'(bus.out_valid), int'(exp_valid));
                check("in_ready", int'(bus.in_ready),
                      int'(!(q.size() == 3 && exp_valid && !bus.out_ready)));
                if (bus.out_valid && q.size() > 0) begin
                    check("char_out", int'(bus.char_out), q[0].ch);
                    check("out_err", int'(bus.out_err), q[0].err);
                    if (bus.out_ready) void'(q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) begin
                    model(int'(bus.char_in), int'(bus.pos_l), int'(bus.pos_m), int'(bus.pos_r),
                          int'(bus.ring_l), int'(bus.ring_m), int'(bus.ring_r), oc, oe);
                    e.ch = oc;
                    e.err = oe;
                    e.acc = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    // out_ready driver
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one letter and hold it until accepted (bounded).
    task automatic send(input int c, input int pl, input int pm, input int pr,
                        input int rl, input int rm, input int rr);
        int guard;
        bus.char_in = 5'(c);
        bus.pos_l = 5'(pl); bus.pos_m = 5'(pm); bus.pos_r = 5'(pr);
        bus.ring_l = 5'(rl); bus.ring_m = 5'(rm); bus.ring_r = 5'(rr);
        bus.in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 300) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 400) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 400) check("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Hand-computed vector: pin the model, then the DUT output and latency.
    task automatic directed(input string name, input int c, input int pl, input int pm,
                            input int pr, input int rl, input int rm, input int rr,
                            input int exp_c, input int exp_e);
        int oc;
        int oe;
        int n;
        drain();
        model(c, pl, pm, pr, rl, rm, rr, oc, oe);
        check({name, "_model_char"}, oc, exp_c);
        check({name, "_model_err"}, oe, exp_e);
        send(c, pl, pm, pr, rl, rm, rr);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        check({name, "_latency"}, n, 3);
        check({name, "_dut_char"}, int'(bus.char_out), exp_c);
        check({name, "_dut_err"}, int'(bus.out_err), exp_e);
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd_field();
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, 31));
        return int'($urandom_range(0, 25));
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.char_in = '0;
        bus.pos_l = '0; bus.pos_m = '0; bus.pos_r = '0;
        bus.ring_l = '0; bus.ring_m = '0; bus.ring_r = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;

        directed("known_S", 18, 0, 0, 1, 0, 0, 0, 1, 0);
        directed("zero_A", 0, 0, 0, 0, 0, 0, 0, 3, 0);
        directed("pos25_ring25", 0, 25, 25, 25, 25, 25, 25, 3, 0);
        directed("pos0_ring25", 0, 0, 0, 0, 25, 25, 25, 20, 0);
        directed("err_char27", 27, 0, 0, 0, 0, 0, 0, 0, 1);
        directed("err_posm30", 5, 0, 30, 0, 0, 0, 0, 0, 1);
        directed("after_err", 0, 0, 0, 0, 0, 0, 0, 3, 0);

        // Sweep all letters back to back at zero settings.
        for (int i = 0; i < 26; i++) send(i, 0, 0, 0, 0, 0, 0);
        // t = 76 and low-t corners.
        send(25, 25, 25, 25, 0, 0, 0);
        send(0, 0, 0, 0, 25, 25, 25);
        send(1, 0, 0, 0, 25, 25, 25);
        send(24, 25, 25, 25, 0, 0, 0);
        drain();

        // Back-pressure: 10 letters, random ready, with a 5-cycle hold low.
        ready_mode = 1;
        fork
            for (int i = 0; i < 10; i++)
                send(int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                     int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                     int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                     int'($urandom_range(0, 25)));
            begin
                repeat (2) @(posedge clk);
                ready_mode = 2;
                repeat (5) @(posedge clk);
                ready_mode = 1;
            end
        join
        drain();

        // Randomized stream with occasional out-of-range fields and gaps.
        for (int i = 0; i < 300; i++) begin
            send(rnd_field(), rnd_field(), rnd_field(), rnd_field(),
                 rnd_field(), rnd_field(), rnd_field());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Full throughput.
        ready_mode = 0;
        for (int i = 0; i < 20; i++)
            send(int'($urandom_range(0, 25)), i % 26, (i * 3) % 26, (i * 7) % 26,
                 (i * 5) % 26, (i * 11) % 26, (i * 13) % 26);
        drain();

        // Asynchronous reset with three letters in flight.
        ready_mode = 2;
        send(3, 1, 2, 3, 4, 5, 6);
        send(4, 1, 2, 3, 4, 5, 6);
        send(5, 1, 2, 3, 4, 5, 6);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", int'(bus.out_valid), 0);
        check("async_rst_char_out", int'(bus.char_out), 0);
        check("async_rst_in_ready", int'(bus.in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (6) @(negedge clk);
        check("no_stale_after_rst", int'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        directed("post_rst", 18, 0, 0, 1, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
